// File: rtl/rv_inst_encoder.sv
// Streaming RV32I encoder: turns decoded field bundles (OP, OP-IMM, BRANCH, LUI)
// into packed instruction words behind a main output register and a one-entry skid buffer.
module rv_inst_encoder #(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_cls,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic              out_err,
  output logic [CNT_W-1:0]  enc_cnt,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic [31:0]      enc_inst;
  logic             enc_err;
  logic [6:0]       f7;
  logic             imm12_ok;
  logic             imm13_ok;
  logic             is_shift;

  logic             main_valid_q, main_valid_d;
  logic [31:0]      main_inst_q, main_inst_d;
  logic             main_err_q, main_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [31:0]      skid_inst_q, skid_inst_d;
  logic             skid_err_q, skid_err_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             accept;
  logic             xfer;

  // Field packing and legality; an illegal bundle collapses to the canonical NOP.
  always_comb begin
    f7       = in_alt ? 7'b0100000 : 7'b0000000;
    imm12_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    imm13_ok = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    enc_inst = 32'h0;
    enc_err  = 1'b0;
    case (in_cls)
      2'd0: begin
        enc_inst = {f7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
        enc_err  = in_alt && !((in_funct3 == 3'b000) || (in_funct3 == 3'b101));
      end
      2'd1: begin
        if (is_shift) begin
          enc_inst = {f7, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          enc_err  = (|in_imm[31:5]) || (in_alt && (in_funct3 == 3'b001));
        end else begin
          enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          enc_err  = !imm12_ok || in_alt;
        end
      end
      2'd2: begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], 7'b1100011};
        enc_err  = in_imm[0] || !imm13_ok ||
                   (in_funct3 == 3'b010) || (in_funct3 == 3'b011);
      end
      default: begin
        enc_inst = {in_imm[31:12], in_rd, 7'b0110111};
        enc_err  = |in_imm[11:0];
      end
    endcase
    if (enc_err) enc_inst = NOP_INST;
  end

  assign accept = in_valid && !skid_valid_q;
  assign xfer   = main_valid_q && out_ready;

  // Skid only fills when main is held; in_ready therefore depends on state alone.
  always_comb begin
    main_valid_d = main_valid_q;
    main_inst_d  = main_inst_q;
    main_err_d   = main_err_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_err_d   = skid_err_q;
    enc_cnt_d    = enc_cnt_q;
    err_cnt_d    = err_cnt_q;
    if (xfer) begin
      enc_cnt_d = enc_cnt_q + 1'b1;
      if (main_err_q && (err_cnt_q != {ERR_W{1'b1}})) err_cnt_d = err_cnt_q + 1'b1;
      if (skid_valid_q) begin
        main_inst_d  = skid_inst_q;
        main_err_d   = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_inst_d = enc_inst;
        main_err_d  = enc_err;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_valid_d = 1'b1;
        skid_inst_d  = enc_inst;
        skid_err_d   = enc_err;
      end else begin
        main_valid_d = 1'b1;
        main_inst_d  = enc_inst;
        main_err_d   = enc_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_inst_q  <= 32'h0;
      main_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= 32'h0;
      skid_err_q   <= 1'b0;
      enc_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_inst_q  <= main_inst_d;
      main_err_q   <= main_err_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_err_q   <= skid_err_d;
      enc_cnt_q    <= enc_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_inst  = main_inst_q;
  assign out_err   = main_err_q;
  assign enc_cnt   = enc_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/rv_inst_encoder.md
Name: rv_inst_encoder

Overview:
Streaming RV32I instruction encoder. It takes decoded instruction fields (class, funct3, alt flag, registers, immediate) and emits packed 32-bit instruction words. It is the inverse of the core's decode path. It feeds the test-program loader and the instruction-memory writer, and is used to build self-checking programs for the decoder. It covers the classes OP, OP-IMM, BRANCH and LUI, using the team's opcode/funct3/funct7 encodings, and has a valid/ready input, a skid-buffered valid/ready output, and illegal-field detection.

Parameters:
CNT_W, 16, width of the encoded-word counter
ERR_W, 8, width of the saturating error counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept the bundle
in_cls  in  2  0=OP, 1=OP-IMM, 2=BRANCH, 3=LUI
in_funct3  in  3  funct3 field
in_alt  in  1  selects SUB/SRA/SRAI (funct7=0100000)
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  32  full signed immediate / byte offset / upper value
out_valid  out  1  encoded word valid
out_ready  in  1  downstream accepts the word
out_inst  out  32  encoded instruction
out_err  out  1  the bundle was illegal; out_inst is the NOP 0x00000013
enc_cnt  out  CNT_W  words transferred on the output (wraps)
err_cnt  out  ERR_W  illegal words transferred (saturates at all-ones)

Behaviour:
- Opcode field = {class opcode[6:2], 2'b11}: OP=01100, OP-IMM=00100, BRANCH=11000, LUI=01101.
- OP encoding: {f7, rs2, rs1, f3, rd, op}.
  - f7 = in_alt ? 0100000 : 0000000.
  - Illegal if in_alt=1 and f3 is not 000 or 101.
- OP-IMM, f3=001 or 101 (shifts): {f7, imm[4:0], rs1, f3, rd, op}.
  - Illegal if imm[31:5]!=0.
  - Illegal if in_alt=1 with f3=001.
- OP-IMM, other f3: {imm[11:0], rs1, f3, rd, op}.
  - Illegal if imm[31:11] is not all-equal (value does not fit 12-bit signed).
  - Illegal if in_alt=1.
- BRANCH encoding: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - Illegal if imm[0]=1.
  - Illegal if imm[31:12] is not all-equal.
  - Illegal if f3 is 010 or 011.
  - in_rd is ignored.
- LUI encoding: {imm[31:12], rd, op}.
  - Illegal if imm[11:0]!=0.
  - rs1, rs2, f3 and alt are ignored.
- Illegal bundle: out_inst=32'h00000013, out_err=1. The bundle still consumes one slot and keeps its order in the stream.
- Pipeline is a main output register plus a one-entry skid register.
  - Accept happens when in_valid & in_ready. The word is visible on out_* the next cycle (latency 1).
  - in_ready = ~skid_valid (registered, no combinational path from out_ready).
  - Throughput is 1 word/cycle while out_ready=1.
- Stall: if the main register is valid, out_ready=0 and a bundle is accepted, that bundle goes to the skid register. in_ready drops the next cycle.
- Drain: on an output transfer with skid valid, skid moves to main and in_ready rises the next cycle. Order is strictly FIFO.
- Simultaneous accept and output transfer with skid empty: main is reloaded with the new word. out_valid stays 1 and there is no bubble.
- out_* are stable while out_valid=1 and out_ready=0.
- enc_cnt increments on each out_valid & out_ready, wrapping 2^CNT_W-1 -> 0.
- err_cnt increments on each output transfer with out_err=1, and holds at all-ones.
- Reset (any cycle, including mid-stall): out_valid=0, skid empty, in_ready=1, out_inst=0, out_err=0, enc_cnt=0, err_cnt=0. In-flight words are discarded.
- Values on in_* are don't-care when in_valid=0.

Test Plan:
- ADD x3,x1,x2 then SUB x3,x1,x2, out_ready=1 -> 0x002081B3 then 0x402081B3 on consecutive cycles, each 1 cycle after accept; enc_cnt=2.
- ADDI x1,x0,imm=0xFFFFFFFF -> 0xFFF00093. SRAI x5,x6,3 (alt=1) -> 0x40335293. SLLI with imm=32 -> 0x00000013, out_err=1, err_cnt=1.
- BEQ rs1=1,rs2=2,imm=8 -> 0x00208463. The same with imm=7, or with f3=010 -> NOP and out_err=1.
- LUI x1,imm=0x12345000 -> 0x123450B7. LUI with imm=0x12345001 -> NOP and out_err=1.
- Backpressure: out_ready=0, offer 3 back-to-back bundles -> 2 accepted, in_ready=0 from the 3rd cycle. Release out_ready -> words out in order with no loss or duplicate; in_ready returns 1 cycle after the first drain.
- Assert reset while stalled with both entries full -> next cycle out_valid=0, in_ready=1, counters=0. Force 300 illegal bundles -> err_cnt holds at 255.
